uart_cmd_ctrl: RTL
==================

Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART byte receiver and the SPWM generator.
- Parses the framed 5-byte packet [0xAA, ADDR, DATA_H, DATA_L, CHK] from the received byte stream and writes validated 16-bit values into the SPWM configuration registers.
- Pulses an update strobe on each successful write.
- Drops malformed or stalled packets and counts them.

Parameters:
- HEADER, 8'hAA, start-of-packet byte.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between bytes inside a packet (20 ms at 50 MHz).
- MOD_MAX, 16'd1000, upper clamp for mod_index.
- FREQ_RST, 16'd60, reset value of freq_word.
- DT_RST, 8'd10, reset value of dead_time.

Ports:
- clk  in  1  system clock (50 MHz)
- rst  in  1  reset
- rx_data  in  8  received byte from the UART receiver; stable while rx_done=1
- rx_done  in  1  receiver done flag; level signal that rises at the stop bit and stays high until the next start bit
- freq_word  out  16  SPWM reference frequency word (addr 0x00)
- mod_index  out  16  modulation index, 0..MOD_MAX (addr 0x01)
- dead_time  out  8  dead-time cycles (addr 0x02, DATA_L only)
- pwm_enable  out  1  output enable (addr 0x03, DATA_L bit0)
- cfg_update  out  1  one-cycle pulse on any successful register write
- err_count  out  8  saturating count of rejected packets
- busy  out  1  high when state != IDLE

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - freq_word=FREQ_RST, mod_index=0, dead_time=DT_RST, pwm_enable=0.
  - cfg_update=0, err_count=0, busy=0, state=IDLE.
  - rx_done_q=1, so a flag already high across reset does not produce a spurious byte.
  - Timeout counter=0.
- Byte strobe:
  - byte_stb = rx_done & ~rx_done_q, where rx_done_q is rx_done registered.
  - byte_stb is used combinationally in the same cycle and captures rx_data.
- FSM states: IDLE, ADDR, DATA_H, DATA_L, CHK, COMMIT.
  - IDLE: on byte_stb with rx_data==HEADER -> ADDR. Any other byte is ignored silently (no error).
  - ADDR: on byte_stb, latch addr -> DATA_H.
  - DATA_H: on byte_stb, latch dh -> DATA_L.
  - DATA_L: on byte_stb, latch dl -> CHK.
  - CHK: on byte_stb:
    - If rx_data == addr^dh^dl and addr <= 8'h03 -> COMMIT.
    - Otherwise err_count++ -> IDLE.
  - COMMIT (exactly one cycle):
    - Write the addressed register and set cfg_update=1 for that cycle -> IDLE.
    - Addr 0x00: freq_word = {dh,dl}.
    - Addr 0x01: mod_index = min({dh,dl}, MOD_MAX), unsigned compare.
    - Addr 0x02: dead_time = dl.
    - Addr 0x03: pwm_enable = dl[0].
- Latency: checksum rx_done rising edge at cycle N -> COMMIT in N+1 (cfg_update high in N+1) -> new register value visible at N+2.
- Timeout:
  - Counter clears on every byte_stb and in IDLE, and increments in ADDR..CHK.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte_stb: err_count++, state -> IDLE.
  - If byte_stb and timeout occur in the same cycle, the byte wins and there is no error.
- err_count saturates at 8'hFF.
- Bytes arriving during COMMIT: impossible at UART rates; if one does occur it is ignored.
- rst mid-packet: discard the partial packet and restore all reset values, including the configuration registers.
- A header byte received mid-packet is treated as data; there is no resync. Recovery is by checksum error or timeout.

Decomposition:
- Shared include spwm_cfg_defs.vh holds:
  - FSM state encodings (3-bit localparams).
  - Register address constants: ADDR_FREQ=0, ADDR_MOD=1, ADDR_DT=2, ADDR_CTRL=3.
  - HEADER default.
- One sub-module is natural: cmd_timeout.
  - Parameterised down-counter.
  - Inputs: clear, run.
  - Output: expired pulse.
  - Width = $clog2(TIMEOUT_CYCLES).
- The edge detector, FSM and register file stay in the top.

Test Plan:
- Reset with rx_done held high, then release -> no byte accepted; outputs hold reset values (freq_word=60, dead_time=10, err_count=0).
- Bytes AA 00 12 34 26 -> freq_word=16'h1234 two cycles after the last rx_done edge; cfg_update high for exactly one cycle; err_count=0.
- Bytes AA 01 05 DC D8 (1500) -> mod_index=16'h03E8 (clamped to 1000); cfg_update pulses once.
- Bytes AA 00 12 34 27 (bad checksum), then AA 07 00 00 07 (bad address) -> freq_word unchanged, err_count=2, no cfg_update.
- TIMEOUT_CYCLES=100: bytes AA 03, then a 150-cycle gap -> returns to IDLE at the 100th cycle after the last byte, err_count=1. Following AA 03 00 01 02 -> pwm_enable=1.
- Stray bytes 55 13 before AA 02 00 20 22, with rst asserted mid-way through an earlier packet -> stray bytes ignored with no error; the interrupted packet is discarded; dead_time=8'h20.

Source files
------------

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared definitions for the UART command sequencer.
// Holds the FSM state encoding, register address map, default header
// byte and the modulation-index clamp helper.
package uart_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_DATA_H = 3'd2,
    ST_DATA_L = 3'd3,
    ST_CHK    = 3'd4,
    ST_COMMIT = 3'd5
  } cmdState_t;

  localparam logic [7:0] ADDR_FREQ      = 8'h00;
  localparam logic [7:0] ADDR_MOD       = 8'h01;
  localparam logic [7:0] ADDR_DT        = 8'h02;
  localparam logic [7:0] ADDR_CTRL      = 8'h03;
  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;

  // Unsigned upper clamp.
  function automatic logic [15:0] clampMod(input logic [15:0] value,
                                           input logic [15:0] maxValue);
    return (value > maxValue) ? maxValue : value;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_timeout.sv
// Inter-byte timeout for the command sequencer.
// Down-counter loaded with TIMEOUT_CYCLES-1 on clear; decrements while run
// is high and pulses expired in the cycle it sits at zero.
// Ports:
//   clk     in  system clock
//   rst     in  synchronous active-high reset
//   clear   in  reload the counter (byte seen or sequencer idle)
//   run     in  count this cycle (sequencer inside a packet)
//   expired out one-cycle pulse when the allowed gap is used up
module uart_cmd_ctrl_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0] LOAD = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  // Loaded value represents "zero cycles elapsed"; reaching zero means
  // TIMEOUT_CYCLES-1 cycles have gone by since the last clear.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= LOAD;
    end else if (run && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // A clear in the same cycle masks expiry, so a late byte always wins.
  assign expired = run & ~clear & (count == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer between the byte receiver and the SPWM generator.
// Parses [HEADER, ADDR, DATA_H, DATA_L, CHK] packets, writes validated
// values into the SPWM configuration registers and counts rejected packets.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   rx_data, rx_done  received byte and level done flag from the receiver
//   freq_word         reference frequency word (addr 0x00)
//   mod_index         modulation index clamped to MOD_MAX (addr 0x01)
//   dead_time         dead-time cycles (addr 0x02)
//   pwm_enable        output enable (addr 0x03, bit0)
//   cfg_update        one-cycle pulse on each register write
//   err_count         saturating rejected-packet count
//   busy              sequencer is inside a packet or committing
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [15:0] MOD_MAX        = 16'd1000,
  parameter logic [15:0] FREQ_RST       = 16'd60,
  parameter logic [7:0]  DT_RST         = 8'd10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [15:0] freq_word,
  output logic [15:0] mod_index,
  output logic [7:0]  dead_time,
  output logic        pwm_enable,
  output logic        cfg_update,
  output logic [7:0]  err_count,
  output logic        busy
);

  cmdState_t  state, nextState;
  logic       rxDoneQ;
  logic       byteStb;
  logic       errInc;
  logic       expired;
  logic       chkOk;
  logic [7:0] addrQ, dhQ, dlQ;

  // rxDoneQ resets high so a done flag held across reset is not a new byte.
  always_ff @(posedge clk) begin
    if (rst) rxDoneQ <= 1'b1;
    else     rxDoneQ <= rx_done;
  end

  assign byteStb = rx_done & ~rxDoneQ;
  assign chkOk   = (rx_data == (addrQ ^ dhQ ^ dlQ)) && (addrQ <= ADDR_CTRL);

  uart_cmd_ctrl_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uTimeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (byteStb | (state == ST_IDLE)),
    .run     ((state == ST_ADDR) | (state == ST_DATA_H) |
              (state == ST_DATA_L) | (state == ST_CHK)),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    errInc    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (byteStb && (rx_data == HEADER)) nextState = ST_ADDR;
      end
      ST_ADDR, ST_DATA_H, ST_DATA_L: begin
        if (byteStb) begin
          nextState = cmdState_t'(state + 3'd1);
        end else if (expired) begin
          nextState = ST_IDLE;
          errInc    = 1'b1;
        end
      end
      ST_CHK: begin
        if (byteStb) begin
          if (chkOk) begin
            nextState = ST_COMMIT;
          end else begin
            nextState = ST_IDLE;
            errInc    = 1'b1;
          end
        end else if (expired) begin
          nextState = ST_IDLE;
          errInc    = 1'b1;
        end
      end
      ST_COMMIT: nextState = ST_IDLE;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addrQ <= '0;
      dhQ   <= '0;
      dlQ   <= '0;
    end else if (byteStb) begin
      if (state == ST_ADDR)   addrQ <= rx_data;
      if (state == ST_DATA_H) dhQ   <= rx_data;
      if (state == ST_DATA_L) dlQ   <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      freq_word  <= FREQ_RST;
      mod_index  <= '0;
      dead_time  <= DT_RST;
      pwm_enable <= 1'b0;
    end else if (state == ST_COMMIT) begin
      case (addrQ)
        ADDR_FREQ: freq_word  <= {dhQ, dlQ};
        ADDR_MOD:  mod_index  <= clampMod({dhQ, dlQ}, MOD_MAX);
        ADDR_DT:   dead_time  <= dlQ;
        ADDR_CTRL: pwm_enable <= dlQ[0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              err_count <= '0;
    else if (errInc && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
  end

  assign cfg_update = (state == ST_COMMIT);
  assign busy       = (state != ST_IDLE);

endmodule
